usb_transaction_ctrl: RTL and testbench

- Device-side USB 1.1 transaction sequencer that sits above the receiver control unit and the transmitter.
- Consumes decoded packet results from the receiver (pid, packet-done, error).
- Decides the response: ACK/NAK/STALL handshake, or DATA0/DATA1 for IN tokens. Commands the transmitter and manages the shared data buffer.
- Tracks per-direction data toggles, the turnaround/response timeout, and host-side status flags.

---
 rtl/usb_pkg.sv | 47 ++++
 rtl/usb_timeout_timer.sv | 52 +++++
 rtl/usb_transaction_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_usb_transaction_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the device-side USB 1.1 transaction sequencer:
//   - PID codes as delivered by the receiver control unit
//   - packet selector understood by the transmitter (tx_packet_t)
//   - sequencer state encoding (xfer_state_t)
//   - default bus-idle timeout while waiting for DATA or ACK
// -----------------------------------------------------------------------------
package usb_pkg;

  // Receiver PID codes
  localparam logic [2:0] PID_STALL = 3'b000;
  localparam logic [2:0] PID_IN    = 3'b001;
  localparam logic [2:0] PID_OUT   = 3'b010;
  localparam logic [2:0] PID_DATA0 = 3'b011;
  localparam logic [2:0] PID_DATA1 = 3'b100;
  localparam logic [2:0] PID_ACK   = 3'b101;
  localparam logic [2:0] PID_NAK   = 3'b111;

  // Idle clocks tolerated while waiting for DATA (after OUT) or ACK (after our DATA)
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  // Packet selector driven to the transmitter
  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA0 = 3'd1,
    TX_DATA1 = 3'd2,
    TX_ACK   = 3'd3,
    TX_NAK   = 3'd4,
    TX_STALL = 3'd5
  } tx_packet_t;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_SEND      = 3'd2,
    ST_TX_WAIT   = 3'd3,
    ST_WAIT_ACK  = 3'd4
  } xfer_state_t;

  // True for either data PID
  function automatic logic is_data_pid(input logic [2:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_timeout_timer.sv
// -----------------------------------------------------------------------------
// usb_timeout_timer
// Saturating bus-idle counter used while the sequencer waits for the host.
//
// Ports:
//   clk      in   system clock
//   n_rst    in   asynchronous active-low reset
//   clear    in   zero the count on the next edge (has priority over hold)
//   hold     in   freeze the count (sequencer is not waiting on the host)
//   timeout  out  count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module usb_timeout_timer
  import usb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic hold,
  output logic timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    // NOTE: the default assignment first means every path through this block
    // assigns count_d, so no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!hold && (count_q != LAST)) begin
      count_d = count_q + 1'b1;   // saturates at LAST
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      count_q <= count_d;
    end
  end

  assign timeout = (count_q == LAST);

endmodule

// File: rtl/usb_transaction_ctrl.sv
// -----------------------------------------------------------------------------
// usb_transaction_ctrl
// Device-side USB 1.1 transaction sequencer. Watches decoded packets from the
// receiver, chooses the response (handshake or DATA0/DATA1), commands the
// transmitter, flushes the shared data buffer and tracks the data toggles.
//
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   rx_pid             decoded pid from receiver
//   rx_packet_done     one-cycle pulse: receiver finished a packet
//   rx_error           receiver error flag (qualifies rx_packet_done)
//   rx_busy            receiver is mid-packet
//   tx_busy, tx_done   transmitter active / finished packet incl. EOP
//   buffer_occupancy   bytes in the shared data buffer
//   host_tx_size       bytes staged by host for the next IN (0 = none)
//   host_stall         endpoint halted
//   host_ack           pulse: host consumed rx data / acknowledged error
//   tx_packet          packet selector for the transmitter (registered)
//   tx_start           one-cycle transmit request
//   d_mode             device drives the bus (tx_start .. tx_done inclusive)
//   clear_buffer       one-cycle buffer flush request
//   rx_data_valid      OUT payload accepted, awaiting host
//   rx_byte_count      occupancy captured with the accepted DATA packet
//   tx_acked           one-cycle pulse: host ACKed our DATA (registered)
//   xfer_error         sticky transaction error
// -----------------------------------------------------------------------------
module usb_transaction_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_pid,
  input  logic       rx_packet_done,
  input  logic       rx_error,
  input  logic       rx_busy,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic [6:0] buffer_occupancy,
  input  logic [6:0] host_tx_size,
  input  logic       host_stall,
  input  logic       host_ack,
  output logic [2:0] tx_packet,
  output logic       tx_start,
  output logic       d_mode,
  output logic       clear_buffer,
  output logic       rx_data_valid,
  output logic [6:0] rx_byte_count,
  output logic       tx_acked,
  output logic       xfer_error
);

  xfer_state_t state_q, state_d;
  tx_packet_t  tx_packet_q, tx_packet_d;
  logic        rx_toggle_q, rx_toggle_d;
  logic        tx_toggle_q, tx_toggle_d;
  logic        rx_valid_q, rx_valid_d;
  logic [6:0]  rx_count_q, rx_count_d;
  logic        xfer_error_q, xfer_error_d;
  logic        tx_acked_q, tx_acked_d;

  logic        valid_set;
  logic        error_set;
  logic        timer_clear;
  logic        timer_hold;
  logic        timeout;
  logic        rx_ok;
  logic        sent_data;

  assign rx_ok     = rx_packet_done && !rx_error;
  assign sent_data = (tx_packet_q == TX_DATA0) || (tx_packet_q == TX_DATA1);

  // The timer only runs while waiting on the host; activity on the receiver
  // restarts the idle window.
  assign timer_hold = (state_q != ST_WAIT_DATA) && (state_q != ST_WAIT_ACK);

  usb_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (timer_clear),
    .hold    (timer_hold),
    .timeout (timeout)
  );

  // ---------------------------------------------------------------------------
  // Next-state and pulse logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    tx_packet_d  = tx_packet_q;
    rx_toggle_d  = rx_toggle_q;
    tx_toggle_d  = tx_toggle_q;
    rx_count_d   = rx_count_q;
    valid_set    = 1'b0;
    error_set    = 1'b0;
    tx_acked_d   = 1'b0;
    tx_start     = 1'b0;
    clear_buffer = 1'b0;
    timer_clear  = rx_busy;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_ok) begin
          if (rx_pid == PID_OUT) begin
            state_d     = ST_WAIT_DATA;
            timer_clear = 1'b1;
          end else if (rx_pid == PID_IN) begin
            state_d = ST_SEND;
            if (host_stall) begin
              tx_packet_d = TX_STALL;
            end else if (host_tx_size == '0) begin
              tx_packet_d = TX_NAK;
            end else begin
              tx_packet_d = tx_toggle_q ? TX_DATA1 : TX_DATA0;
            end
          end
        end
      end

      ST_WAIT_DATA: begin
        // A completed packet outranks a timeout reached in the same cycle.
        if (rx_packet_done) begin
          if (!rx_error && is_data_pid(rx_pid)) begin
            state_d = ST_SEND;
            if (rx_valid_q) begin
              // Host has not drained the previous payload: refuse this one.
              tx_packet_d  = TX_NAK;
              clear_buffer = 1'b1;
            end else if ((rx_pid == PID_DATA1) == rx_toggle_q) begin
              tx_packet_d = TX_ACK;
              valid_set   = 1'b1;
              rx_count_d  = buffer_occupancy;
              rx_toggle_d = !rx_toggle_q;
            end else begin
              // Retransmission of data already accepted: ACK it again so the
              // host moves on, but discard the duplicate bytes.
              tx_packet_d  = TX_ACK;
              clear_buffer = 1'b1;
            end
          end else begin
            state_d      = ST_IDLE;
            clear_buffer = 1'b1;
            error_set    = 1'b1;
          end
        end else if (timeout) begin
          state_d      = ST_IDLE;
          clear_buffer = 1'b1;
          error_set    = 1'b1;
        end
      end

      ST_SEND: begin
        if (!tx_busy && !rx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        if (tx_done) begin
          tx_packet_d = TX_NONE;
          if (sent_data) begin
            state_d     = ST_WAIT_ACK;
            timer_clear = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (rx_packet_done) begin
          state_d = ST_IDLE;
          if (rx_error) begin
            error_set = 1'b1;
          end else if (rx_pid == PID_ACK) begin
            tx_toggle_d  = !tx_toggle_q;
            tx_acked_d   = 1'b1;
            clear_buffer = 1'b1;
          end
          // NAK or any other pid: give up quietly, keep toggle and buffer.
        end else if (timeout) begin
          state_d   = ST_IDLE;
          error_set = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Setting the flag wins over a host_ack in the same cycle.
    rx_valid_d   = valid_set | (rx_valid_q & ~host_ack);
    xfer_error_d = error_set | (xfer_error_q & ~host_ack);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      tx_packet_q  <= TX_NONE;
      rx_toggle_q  <= 1'b0;
      tx_toggle_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_count_q   <= '0;
      xfer_error_q <= 1'b0;
      tx_acked_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_packet_q  <= tx_packet_d;
      rx_toggle_q  <= rx_toggle_d;
      tx_toggle_q  <= tx_toggle_d;
      rx_valid_q   <= rx_valid_d;
      rx_count_q   <= rx_count_d;
      xfer_error_q <= xfer_error_d;
      tx_acked_q   <= tx_acked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_packet     = tx_packet_q;
  assign rx_data_valid = rx_valid_q;
  assign rx_byte_count = rx_count_q;
  assign tx_acked      = tx_acked_q;
  assign xfer_error    = xfer_error_q;

  // Bus ownership starts with the request itself and lasts through tx_done.
  assign d_mode = tx_start || (state_q == ST_TX_WAIT);

endmodule

// File: tb/tb_usb_transaction_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_transaction_ctrl
// Scoreboard bench: stimulus tasks push expected bus events (buffer flushes,
// transmit requests with their packet code, tx_acked pulses) into a queue
// from a transaction-level model; a monitor pops and compares whenever the DUT
// shows one. A transmitter stand-in answers every tx_start.
// -----------------------------------------------------------------------------
module tb_usb_transaction_ctrl;
  import usb_pkg::*;

  localparam int unsigned TO = DEFAULT_TIMEOUT_CYCLES;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] rx_pid = 3'b000;
  logic       rx_packet_done = 1'b0;
  logic       rx_error = 1'b0;
  logic       rx_busy = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic [6:0] buffer_occupancy = '0;
  logic [6:0] host_tx_size = '0;
  logic       host_stall = 1'b0;
  logic       host_ack = 1'b0;
  logic [2:0] tx_packet;
  logic       tx_start;
  logic       d_mode;
  logic       clear_buffer;
  logic       rx_data_valid;
  logic [6:0] rx_byte_count;
  logic       tx_acked;
  logic       xfer_error;

  usb_transaction_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .rx_pid           (rx_pid),
    .rx_packet_done   (rx_packet_done),
    .rx_error         (rx_error),
    .rx_busy          (rx_busy),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .buffer_occupancy (buffer_occupancy),
    .host_tx_size     (host_tx_size),
    .host_stall       (host_stall),
    .host_ack         (host_ack),
    .tx_packet        (tx_packet),
    .tx_start         (tx_start),
    .d_mode           (d_mode),
    .clear_buffer     (clear_buffer),
    .rx_data_valid    (rx_data_valid),
    .rx_byte_count    (rx_byte_count),
    .tx_acked         (tx_acked),
    .xfer_error       (xfer_error)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_CLR, EV_TX, EV_ACKED} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [2:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  bit  phy_active = 1'b0;

  // Transaction-level model of the endpoint
  bit         m_rx_tog, m_tx_tog, m_valid, m_err;
  logic [6:0] m_count;

  logic [2:0] junk_pids[6] = '{PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL, 3'b110};
  logic [2:0] bad_pids[6]  = '{PID_IN, PID_OUT, PID_ACK, PID_NAK, PID_STALL, 3'b110};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [2:0] c);
    ev_t e;
    e.kind = k;
    e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input logic [2:0] c);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected event: kind %0d code %0d with nothing pending (t=%0t)", k, c, $time);
    end else begin
      e = exp_q.pop_front();
      check("event kind", k, e.kind);
      check("event code", c, e.code);
    end
  endtask

  // Monitor: compare every bus event against the scoreboard
  always @(negedge clk) begin
    if (n_rst) begin
      if (clear_buffer) observe(EV_CLR, 3'd0);
      if (tx_start) begin
        observe(EV_TX, tx_packet);
        check("d_mode at tx_start", d_mode, 1);
        check("bus idle at tx_start", {rx_busy, tx_busy}, 0);
      end
      if (tx_acked) observe(EV_ACKED, 3'd0);
    end
  end

  // Transmitter stand-in
  always begin
    @(negedge clk);
    if (tx_start && n_rst) begin
      phy_active = 1'b1;
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat ($urandom_range(2, 6)) @(posedge clk);
      #1 tx_busy = 1'b0;
      tx_done = 1'b1;
      @(posedge clk); #1 tx_done = 1'b0;
      phy_active = 1'b0;
    end
  end

  // Watchdog
  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic send_pkt(input logic [2:0] pid, input bit err, input bit ack_too);
    @(posedge clk); #1 rx_busy = 1'b1;
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 rx_busy = 1'b0;
    rx_pid = pid;
    rx_error = err;
    rx_packet_done = 1'b1;
    host_ack = ack_too;
    @(posedge clk); #1 rx_packet_done = 1'b0;
    rx_error = 1'b0;
    host_ack = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !phy_active) break;
    end
    check("drain completes", {31'd0, (exp_q.size() != 0) || phy_active}, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, " rx_data_valid"}, rx_data_valid, m_valid);
    check({tag, " rx_byte_count"}, rx_byte_count, m_count);
    check({tag, " xfer_error"}, xfer_error, m_err);
    check({tag, " tx_packet idle"}, tx_packet, TX_NONE);
  endtask

  task automatic host_ack_pulse();
    @(posedge clk); #1 host_ack = 1'b1;
    @(posedge clk); #1 host_ack = 1'b0;
    m_valid = 1'b0;
    m_err = 1'b0;
    check("host_ack clears valid", rx_data_valid, 0);
    check("host_ack clears error", xfer_error, 0);
  endtask

  // OUT token followed by a second packet (pid2); ack_too raises host_ack
  // alongside the second packet's done pulse.
  task automatic do_out(input logic [2:0] pid2, input bit err2, input logic [6:0] occ,
                        input bit ack_too);
    bit v_old;
    buffer_occupancy = occ;
    send_pkt(PID_OUT, 1'b0, 1'b0);
    v_old = m_valid;
    if (ack_too) begin
      m_valid = 1'b0;
      m_err = 1'b0;
    end
    if (!err2 && (pid2 == PID_DATA0 || pid2 == PID_DATA1)) begin
      if (v_old) begin
        expect_ev(EV_CLR, 3'd0);
        expect_ev(EV_TX, TX_NAK);
      end else if ((pid2 == PID_DATA1) == m_rx_tog) begin
        expect_ev(EV_TX, TX_ACK);
        m_valid = 1'b1;
        m_count = occ;
        m_rx_tog = !m_rx_tog;
      end else begin
        expect_ev(EV_CLR, 3'd0);
        expect_ev(EV_TX, TX_ACK);
      end
    end else begin
      expect_ev(EV_CLR, 3'd0);
      m_err = 1'b1;
    end
    send_pkt(pid2, err2, ack_too);
    drain();
    check_status("out");
  endtask

  // IN token; resp: 0 ACK, 1 NAK, 2 ACK with rx_error, 3 silence, 4 DATA0 pid
  task automatic do_in(input bit stall, input logic [6:0] size, input int resp);
    bit is_data;
    host_stall = stall;
    host_tx_size = size;
    is_data = !stall && (size != 0);
    if (stall)        expect_ev(EV_TX, TX_STALL);
    else if (!is_data) expect_ev(EV_TX, TX_NAK);
    else              expect_ev(EV_TX, m_tx_tog ? TX_DATA1 : TX_DATA0);
    send_pkt(PID_IN, 1'b0, 1'b0);
    drain();
    if (is_data) begin
      case (resp)
        0: begin
          expect_ev(EV_CLR, 3'd0);
          expect_ev(EV_ACKED, 3'd0);
          m_tx_tog = !m_tx_tog;
          send_pkt(PID_ACK, 1'b0, 1'b0);
        end
        1: send_pkt(PID_NAK, 1'b0, 1'b0);
        2: begin
          m_err = 1'b1;
          send_pkt(PID_ACK, 1'b1, 1'b0);
        end
        4: send_pkt(PID_DATA0, 1'b0, 1'b0);
        default: begin
          m_err = 1'b1;
          repeat (TO + 4) @(posedge clk);
        end
      endcase
      drain();
    end
    check_status("in");
  endtask

  initial begin
    int n;
    m_rx_tog = 0; m_tx_tog = 0; m_valid = 0; m_err = 0; m_count = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_packet", tx_packet, 0);
    check("reset tx_start", tx_start, 0);
    check("reset d_mode", d_mode, 0);
    check("reset clear_buffer", clear_buffer, 0);
    check("reset tx_acked", tx_acked, 0);
    check_status("reset");
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: OUT + DATA0, occupancy 12 -> ACK, payload accepted
    do_out(PID_DATA0, 1'b0, 7'd12, 1'b0);
    // 2: repeat without host_ack -> NAK + flush; with host_ack -> duplicate ACK + flush
    do_out(PID_DATA0, 1'b0, 7'd30, 1'b0);
    host_ack_pulse();
    do_out(PID_DATA0, 1'b0, 7'd40, 1'b0);
    // next data must be DATA1
    do_out(PID_DATA1, 1'b0, 7'd5, 1'b0);
    host_ack_pulse();

    // 3: IN with data staged -> DATA0, ACK flips toggle; then DATA1 with NAK
    do_in(1'b0, 7'd8, 0);
    do_in(1'b0, 7'd8, 1);

    // 4: NAK when nothing staged, STALL when halted, tx_start held off by rx_busy
    do_in(1'b0, 7'd0, 0);
    do_in(1'b1, 7'd8, 0);
    host_stall = 1'b0;
    host_tx_size = 7'd0;
    expect_ev(EV_TX, TX_NAK);
    send_pkt(PID_IN, 1'b0, 1'b0);
    rx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("tx_start held while rx_busy", tx_start, 0);
    end
    @(posedge clk); #1 rx_busy = 1'b0;
    @(negedge clk);
    check("tx_start first idle cycle", tx_start, 1);
    drain();

    // 5: OUT then silence -> flush + error after exactly TO cycles
    expect_ev(EV_CLR, 3'd0);
    m_err = 1'b1;
    send_pkt(PID_OUT, 1'b0, 1'b0);
    n = 0;
    for (int i = 1; i <= 2 * TO; i++) begin
      @(negedge clk);
      if (clear_buffer) begin
        n = i;
        break;
      end
    end
    check("WAIT_DATA timeout latency", n, TO);
    drain();
    check_status("timeout");
    host_ack_pulse();
    // bad pid in WAIT_DATA with host_ack the same cycle: error still set
    do_out(PID_ACK, 1'b0, 7'd3, 1'b1);
    host_ack_pulse();
    // IN with no ACK: error, toggle and buffer kept
    do_in(1'b0, 7'd16, 3);
    host_ack_pulse();

    // 6: reset in the middle of a transmission
    host_stall = 1'b0;
    host_tx_size = 7'd8;
    expect_ev(EV_TX, m_tx_tog ? TX_DATA1 : TX_DATA0);
    send_pkt(PID_IN, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_busy) break;
    end
    check("d_mode during transmission", d_mode, 1);
    #1 n_rst = 1'b0;
    #1;
    check("mid-reset tx_packet", tx_packet, 0);
    check("mid-reset d_mode", d_mode, 0);
    check("mid-reset tx_start", tx_start, 0);
    check("mid-reset clear_buffer", clear_buffer, 0);
    check("mid-reset tx_acked", tx_acked, 0);
    m_rx_tog = 0; m_tx_tog = 0; m_valid = 0; m_err = 0; m_count = '0;
    check_status("mid-reset");
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (!phy_active) break;
    end
    @(posedge clk); #1 n_rst = 1'b1;
    do_in(1'b0, 7'd8, 0);
    do_out(PID_DATA0, 1'b0, 7'd20, 1'b0);
    host_ack_pulse();

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0, 1: do_out($urandom_range(0, 1) ? PID_DATA1 : PID_DATA0, 1'b0,
                     7'($urandom_range(0, 64)), 1'($urandom_range(0, 1)));
        2: begin
          if ($urandom_range(0, 1))
            do_out(bad_pids[$urandom_range(0, 5)], 1'b0, 7'($urandom_range(0, 64)), 1'b0);
          else
            do_out($urandom_range(0, 1) ? PID_DATA1 : PID_DATA0, 1'b1,
                   7'($urandom_range(0, 64)), 1'b0);
        end
        3, 4: begin
          n = $urandom_range(0, 3);
          do_in($urandom_range(0, 4) == 0,
                ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 64)),
                (n == 3) ? 4 : n);
        end
        default: begin
          // Packets IDLE must ignore
          if ($urandom_range(0, 1))
            send_pkt(junk_pids[$urandom_range(0, 5)], 1'b0, 1'b0);
          else
            send_pkt($urandom_range(0, 1) ? PID_IN : PID_OUT, 1'b1, 1'b0);
          drain();
          check_status("idle junk");
        end
      endcase
      if ($urandom_range(0, 2) == 0) host_ack_pulse();
    end

    drain();
    check("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
